des_key_sched: RTL and testbench
================================

Name: des_key_sched

Overview:
Sequential DES key-schedule generator. Applies PC-1 to a 64-bit key, performs the per-round C/D rotations, and streams the 16 PC-2 round keys over a valid/ready interface. Supports encrypt order (K1..K16) and decrypt order (K16..K1) by rotating right instead of left. Optional key parity check. Feeds the round datapath of the DES core, one key per accepted beat.

Parameters:
CHECK_PARITY, 0, 1 = check odd parity of each key_in byte at start and report on parity_err; 0 = parity_err tied low.
NUM_ROUNDS, 16, rounds issued per schedule; legal 1..16; decrypt mode legal only with 16.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  load key_in and begin a schedule; honoured only when busy=0
decrypt  input  1  sampled with start; 0 = K1..K16 order, 1 = K16..K1 order
key_in  input  64  DES key; key_in[63] = DES bit 1; parity bits ignored by PC-1
flush  input  1  synchronous abort; returns to IDLE next edge
key_ready  input  1  downstream accepts round_key this cycle
round_key  output  48  current round key; round_key[47] = PC-2 output bit 1
key_valid  output  1  round_key valid
round_idx  output  4  issue index 0..NUM_ROUNDS-1 of the current key
key_last  output  1  key_valid on final key of schedule
busy  output  1  schedule in progress
parity_err  output  1  sticky per schedule; some key_in byte had even parity

Behaviour:
- Reset (rst_n low, async): state IDLE, cd=0, key_valid=0, key_last=0, round_idx=0, busy=0, parity_err=0; round_key = PC-2(0) = 0.
- Internal cd register 56 bits: C = cd[55:28], D = cd[27:0]; DES bit n of CD maps to cd[56-n].
- Shift table s(1..16) = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- round_key = PC-2(cd), combinational from the register; no extra latency beyond cd.
- States: IDLE, RUN.
- IDLE: start=1 at edge T -> at T+1: state RUN, busy=1, key_valid=1, round_idx=0, mode latched.
  - encrypt: cd = rotl28 of each half of PC-1(key_in) by 1 (C1D1).
  - decrypt: cd = PC-1(key_in) (C0D0 = C16D16).
  - parity_err = CHECK_PARITY & (any key_in byte has even popcount); otherwise cleared.
- RUN, beat accepted (key_valid & key_ready), issue index r = round_idx+1:
  - encrypt: cd <= both halves rotl by s(r+1); round_idx++.
  - decrypt: cd <= both halves rotr by s(17-r); round_idx++.
  - If round_idx = NUM_ROUNDS-1: go to IDLE, key_valid=0, busy=0; cd holds.
- key_ready=0: cd, round_idx, round_key stable (stall, no limit).
- key_last = key_valid & (round_idx == NUM_ROUNDS-1).
- start while busy=1: ignored; no restart, latched key unchanged.
- flush=1: next edge IDLE, key_valid=0, busy=0, round_idx=0; flush has priority over start and over beat acceptance in the same cycle.
- Same-cycle final accept and start: start ignored (busy still 1); new start is accepted no earlier than the cycle after busy falls.
- parity_err holds until the next accepted start or reset.
- decrypt with NUM_ROUNDS<16: not supported; behaviour undefined, checked by assertion only.

Test Plan:
- Encrypt, key_in=0x133457799BBCDFF1, key_ready=1 -> key_valid at T+1; K1=0x1B02EFFC7072, K2=0x79AED9DBC9E5, K16=0xCB3D8B0E17F5 with key_last=1, round_idx 0..15; busy falls after 16 beats; parity_err=0.
- Decrypt, same key -> first key 0xCB3D8B0E17F5, second 0x... equal to encrypt K15, last key 0x1B02EFFC7072; full sequence is the exact reverse of encrypt.
- Random key_ready backpressure (~50%) on the same key -> identical 16-key sequence, round_key stable while key_ready=0, no dropped or duplicated keys.
- CHECK_PARITY=1, key_in=0x0000000000000000 -> parity_err=1, all 16 keys 0x000000000000; next start with 0x133457799BBCDFF1 clears parity_err to 0.
- flush asserted at round_idx=5 -> next cycle key_valid=0, busy=0; a following start restarts cleanly from K1; start pulsed mid-schedule has no effect.
- rst_n low asynchronously at round_idx=9 mid-stall -> outputs immediately at reset values; after release, a start runs a full correct schedule.

Source files
------------

// File: rtl/des_key_sched.sv
// Sequential DES key-schedule generator: PC-1 load, per-round C/D rotation, PC-2 round keys
// streamed over valid/ready in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_sched #(
  parameter int CHECK_PARITY = 0,
  parameter int NUM_ROUNDS   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key_in,
  input  logic        flush,
  input  logic        key_ready,
  output logic [47:0] round_key,
  output logic        key_valid,
  output logic [3:0]  round_idx,
  output logic        key_last,
  output logic        busy,
  output logic        parity_err
);
  // state | meaning
  // IDLE  | no schedule; waiting for start
  // RUN   | round_key valid, advancing on each accepted beat
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // DES bit n of a W-bit vector lives at index W-n
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] v);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = v[6'(56 - PC2[i])];
    return r;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] h, input logic left, input logic one);
    if (left) return one ? {h[26:0], h[27]} : {h[25:0], h[27:26]};
    return one ? {h[0], h[27:1]} : {h[1:0], h[27:2]};
  endfunction

  function automatic logic s_one(input logic [4:0] n);
    return (n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16);
  endfunction

  state_t      state, state_nxt;
  logic [55:0] cd, pc1_key, cd_step;
  logic        mode_dec, accept, load, last_idx, par_bad, step_one;

  assign key_valid = (state == RUN);
  assign busy      = key_valid;
  assign last_idx  = (round_idx == LAST_IDX);
  assign key_last  = key_valid && last_idx;
  assign accept    = key_valid && key_ready;
  assign load      = (state == IDLE) && start && !flush;
  assign round_key = pc2(cd);
  assign pc1_key   = pc1(key_in);

  // encrypt leaves round r for r+1 with s(r+1); decrypt undoes round 17-r with s(17-r)
  assign step_one = mode_dec ? s_one(5'd16 - {1'b0, round_idx})
                             : s_one({1'b0, round_idx} + 5'd2);
  assign cd_step  = {rot28(cd[55:28], !mode_dec, step_one), rot28(cd[27:0], !mode_dec, step_one)};

  always_comb begin
    par_bad = 1'b0;
    for (int b = 0; b < 8; b++) par_bad = par_bad | ~(^key_in[8*b +: 8]);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !flush) state_nxt = RUN;
      RUN:     if (flush || (accept && last_idx)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd         <= '0;
      round_idx  <= '0;
      mode_dec   <= 1'b0;
      parity_err <= 1'b0;
    end else if (flush) begin
      round_idx <= '0;
    end else if (load) begin
      mode_dec   <= decrypt;
      round_idx  <= '0;
      cd         <= decrypt ? pc1_key
                            : {rot28(pc1_key[55:28], 1'b1, 1'b1), rot28(pc1_key[27:0], 1'b1, 1'b1)};
      parity_err <= (CHECK_PARITY != 0) && par_bad;
    end else if (accept) begin
      if (last_idx) begin
        round_idx <= '0;
      end else begin
        round_idx <= round_idx + 4'd1;
        cd        <= cd_step;
      end
    end
  end

  // reverse order only lines up with the key when the full 16 rounds are issued
  assert property (@(posedge clk) disable iff (!rst_n)
                   (start && !busy && !flush && decrypt) |-> (NUM_ROUNDS == 16));

endmodule

// File: tb/tb_des_key_sched.sv
// Bench for des_key_sched: per-cycle comparison against a cumulative-shift DES key model,
// plus literal round keys from the classic 133457799BBCDFF1 example.
module tb_des_key_sched;
  localparam int CHK_PAR = 1;
  localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_A   = 48'h1B02EFFC7072;
  localparam logic [47:0] K2_A   = 48'h79AED9DBC9E5;
  localparam logic [47:0] K15_A  = 48'hBF918D3D3F0A;
  localparam logic [47:0] K16_A  = 48'hCB3D8B0E17F5;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n, start, decrypt, flush, key_ready;
  logic [63:0] key_in;
  logic [47:0] round_key;
  logic        key_valid, key_last, busy, parity_err;
  logic [3:0]  round_idx;

  int tests = 0;
  int fails = 0;

  logic [47:0] mk [1:16];
  logic [47:0] seen [0:31];

  logic [47:0] m_seq [0:15];
  bit          m_active = 1'b0;
  int          m_pos = 0;
  bit          m_par = 1'b0;

  des_key_sched #(.CHECK_PARITY(CHK_PAR), .NUM_ROUNDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key_in(key_in),
    .flush(flush), .key_ready(key_ready), .round_key(round_key), .key_valid(key_valid),
    .round_idx(round_idx), .key_last(key_last), .busy(busy), .parity_err(parity_err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // C_r/D_r are C0/D0 rotated left by the running shift total; no per-round state kept
  function automatic void build(input logic [63:0] k);
    bit kb [1:64];
    bit c [28];
    bit d [28];
    int tot, p;
    logic [47:0] rk;
    for (int n = 1; n <= 64; n++) kb[n] = k[64-n];
    for (int j = 0; j < 28; j++) begin
      c[j] = kb[PC1[j]];
      d[j] = kb[PC1[28+j]];
    end
    tot = 0;
    for (int r = 1; r <= 16; r++) begin
      tot += SHIFTS[r-1];
      rk = '0;
      for (int i = 0; i < 48; i++) begin
        p = PC2[i];
        rk[47-i] = (p <= 28) ? c[(p - 1 + tot) % 28] : d[(p - 29 + tot) % 28];
      end
      mk[r] = rk;
    end
  endfunction

  function automatic bit bad_parity(input logic [63:0] k);
    bit bad = 1'b0;
    for (int b = 0; b < 8; b++) if ($countones(k[8*b +: 8]) % 2 == 0) bad = 1'b1;
    return bad;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", key_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_idx", round_idx, 0);
      chk("rst_last", key_last, 0);
      chk("rst_par", parity_err, 0);
      chk("rst_key", round_key, 0);
      m_active = 1'b0;
      m_par    = 1'b0;
    end else begin
      chk("cyc_valid", key_valid, m_active);
      chk("cyc_busy", busy, m_active);
      chk("cyc_par", parity_err, m_par);
      if (m_active) begin
        chk("cyc_key", round_key, m_seq[m_pos]);
        chk("cyc_idx", round_idx, m_pos);
        chk("cyc_last", key_last, m_pos == 15);
      end else begin
        chk("cyc_last_idle", key_last, 0);
      end
      if (flush) begin
        m_active = 1'b0;
      end else if (m_active) begin
        if (key_ready) begin
          m_pos++;
          if (m_pos == 16) m_active = 1'b0;
        end
      end else if (start) begin
        build(key_in);
        for (int i = 0; i < 16; i++) m_seq[i] = decrypt ? mk[16-i] : mk[i+1];
        m_pos    = 0;
        m_active = 1'b1;
        m_par    = (CHK_PAR != 0) && bad_parity(key_in);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] k, input logic dec);
    start = 1'b1; key_in = k; decrypt = dec;
    tick();
    start = 1'b0;
  endtask

  task automatic run_sched(input bit rnd, output int n);
    int cyc = 0;
    n = 0;
    while (busy && cyc < 400) begin
      key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (key_valid && key_ready) begin
        if (n < 32) seen[n] = round_key;
        n++;
      end
      tick();
      cyc++;
    end
    chk("sched_done", busy, 0);
    key_ready = 1'b1;
  endtask

  task automatic wait_idx(input int idx);
    int cyc = 0;
    while (!(key_valid && round_idx == 4'(idx)) && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("wait_idx", round_idx, idx);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; flush = 1'b0; key_ready = 1'b1; key_in = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    build(KEY_A);
    chk("model_k1", mk[1], K1_A);
    chk("model_k2", mk[2], K2_A);
    chk("model_k15", mk[15], K15_A);
    chk("model_k16", mk[16], K16_A);
    chk("model_par_a", bad_parity(KEY_A), 0);
    chk("model_par_0", bad_parity(64'h0), 1);

    do_start(KEY_A, 1'b0);
    chk("enc_first_valid", key_valid, 1);
    chk("enc_first_idx", round_idx, 0);
    chk("enc_first_key", round_key, K1_A);
    run_sched(1'b0, n);
    chk("enc_beats", n, 16);
    chk("enc_k2", seen[1], K2_A);
    chk("enc_k16", seen[15], K16_A);
    chk("enc_par", parity_err, 0);

    do_start(KEY_A, 1'b1);
    run_sched(1'b0, n);
    chk("dec_beats", n, 16);
    chk("dec_first", seen[0], K16_A);
    chk("dec_second", seen[1], K15_A);
    chk("dec_last", seen[15], K1_A);

    do_start(KEY_A, 1'b0);
    run_sched(1'b1, n);
    chk("bp_beats", n, 16);
    build(KEY_A);
    for (int i = 0; i < 16; i++) chk("bp_key", seen[i], mk[i+1]);

    do_start(64'h0, 1'b0);
    chk("par_set", parity_err, 1);
    run_sched(1'b0, n);
    chk("par_k4_zero", seen[3], 0);
    chk("par_k16_zero", seen[15], 0);
    chk("par_sticky", parity_err, 1);
    do_start(KEY_A, 1'b0);
    chk("par_clear", parity_err, 0);
    run_sched(1'b0, n);

    do_start(KEY_A, 1'b0);
    wait_idx(5);
    flush = 1'b1; start = 1'b1; key_in = 64'h0;
    tick();
    flush = 1'b0; start = 1'b0;
    chk("flush_valid", key_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_idx", round_idx, 0);
    flush = 1'b1; start = 1'b1; key_in = KEY_A;
    tick();
    flush = 1'b0; start = 1'b0;
    chk("flush_beats_start", busy, 0);
    do_start(KEY_A, 1'b0);
    chk("restart_k1", round_key, K1_A);
    wait_idx(3);
    start = 1'b1; key_in = 64'h0; decrypt = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_start_idx", round_idx, 4);
    chk("mid_start_par", parity_err, 0);
    run_sched(1'b0, n);
    chk("mid_start_beats", n, 12);
    chk("mid_start_k16", seen[11], K16_A);

    do_start(KEY_A, 1'b1);
    wait_idx(15);
    chk("fin_last", key_last, 1);
    start = 1'b1; key_in = KEY_A; decrypt = 1'b0;
    tick();
    start = 1'b0;
    chk("fin_start_ignored", busy, 0);
    do_start(KEY_A, 1'b0);
    chk("after_fin_k1", round_key, K1_A);
    run_sched(1'b0, n);

    do_start(KEY_A, 1'b0);
    wait_idx(9);
    key_ready = 1'b0;
    tick();
    tick();
    chk("stall_idx", round_idx, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", key_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_idx", round_idx, 0);
    chk("arst_key", round_key, 0);
    key_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_start(KEY_A, 1'b0);
    run_sched(1'b0, n);
    chk("post_rst_beats", n, 16);
    chk("post_rst_k1", seen[0], K1_A);
    chk("post_rst_k16", seen[15], K16_A);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
